// File: rtl/uart_pkg.sv
// Shared UART/ALU definitions: sequencer states, default widths and the opcode map
// decoded by the ALU, so sequencer and ALU agree on encodings.
package uart_pkg;

  localparam int NB_DATA_DFLT = 8;
  localparam int NB_OP_DFLT   = 6;

  typedef enum logic [2:0] {
    S_OPA  = 3'd0,
    S_OPB  = 3'd1,
    S_OPC  = 3'd2,
    S_EXEC = 3'd3,
    S_SEND = 3'd4
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // States in which a frame byte may be popped from RX.
  function automatic logic is_rx_state(input state_t s);
    return (s == S_OPA) || (s == S_OPB) || (s == S_OPC);
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte frame timer: clear wins over enable, count saturates at all-ones,
// expire_o is a combinational pulse on the clock that would pass TIMEOUT-1.
module uart_frame_timer #(
  parameter int TIMEOUT = 50000,
  parameter int NB_TMR  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [NB_TMR-1:0] LAST = (TIMEOUT > 0) ? NB_TMR'(TIMEOUT - 1) : '0;
  localparam logic              ARMED = (TIMEOUT > 0);

  logic [NB_TMR-1:0] count_q;
  logic [NB_TMR-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + NB_TMR'(1);
    end
  end

  assign expire_o = ARMED && en_i && !clr_i && (count_q == LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_alu_sequencer.sv
// Frames A, B, opcode bytes from the RX FIFO into the ALU and pushes one result byte to TX.
// Opcode pop to earliest TX push is two clocks; a full TX FIFO stalls the result indefinitely.
module uart_alu_sequencer
  import uart_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DFLT,
  parameter int NB_OP   = NB_OP_DFLT,
  parameter int TIMEOUT = 50000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               rx_empty,
  input  logic [NB_DATA-1:0] r_data,
  output logic               rd_uart,
  input  logic               tx_full,
  output logic [NB_DATA-1:0] w_data,
  output logic               wr_uart,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_busy,
  output logic               o_timeout
);

  state_t             state_q, state_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [NB_DATA-1:0] wdata_q, wdata_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               to_q, to_d;

  logic pop_go;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_expire;

  // The FIFO only retires the head on the clock after rd_uart, so its flags are
  // stale for one cycle; skipping that cycle keeps us from double-reading a byte.
  assign pop_go  = is_rx_state(state_q) && !rx_empty && !rd_q;
  assign tmr_clr = pop_go || (state_q == S_OPA) || (state_q == S_EXEC) || (state_q == S_SEND);
  assign tmr_en  = ((state_q == S_OPB) || (state_q == S_OPC)) && !pop_go;

  uart_frame_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_frame_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    to_d     = 1'b0;
    wdata_d  = wdata_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;

    case (state_q)
      S_OPA: begin
        if (pop_go) begin
          rd_d    = 1'b1;
          a_d     = r_data;
          state_d = S_OPB;
        end
      end
      S_OPB: begin
        if (pop_go) begin
          rd_d    = 1'b1;
          b_d     = r_data;
          state_d = S_OPC;
        end else if (tmr_expire) begin
          to_d    = 1'b1;
          state_d = S_OPA;
        end
      end
      S_OPC: begin
        if (pop_go) begin
          rd_d    = 1'b1;
          op_d    = r_data[NB_OP-1:0];
          state_d = S_EXEC;
        end else if (tmr_expire) begin
          to_d    = 1'b1;
          state_d = S_OPA;
        end
      end
      S_EXEC: begin
        result_d = i_alu_result;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (!tx_full) begin
          wr_d    = 1'b1;
          wdata_d = result_q;
          state_d = S_OPA;
        end
      end
      default: begin
        state_d = S_OPA;
      end
    endcase

    busy_d = (state_d != S_OPA);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_OPA;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      to_q     <= to_d;
    end
  end

  assign rd_uart   = rd_q;
  assign wr_uart   = wr_q;
  assign w_data    = wdata_q;
  assign o_alu_a   = a_q;
  assign o_alu_b   = b_q;
  assign o_alu_op  = op_q;
  assign o_busy    = busy_q;
  assign o_timeout = to_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench for uart_alu_sequencer: RX FIFO model, reference ALU, and a result scoreboard
// checked on every TX push.
module tb_uart_alu_sequencer;
  import uart_pkg::*;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TIMEOUT = 16;

  logic               i_clk = 1'b0;
  logic               i_reset = 1'b0;
  logic               rx_empty = 1'b1;
  logic [NB_DATA-1:0] r_data = '0;
  logic               rd_uart;
  logic               tx_full = 1'b0;
  logic [NB_DATA-1:0] w_data;
  logic               wr_uart;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] i_alu_result;
  logic               o_busy;
  logic               o_timeout;

  logic [7:0] rxq[$];
  logic [7:0] expq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_count = 0;
  int wr_count = 0;
  int to_count = 0;
  int last_rd_cyc = 0;
  int last_wr_cyc = 0;
  int last_to_cyc = 0;
  logic prev_rd = 1'b0;
  logic prev_full = 1'b0;

  always #5 i_clk = ~i_clk;

  uart_alu_sequencer #(
    .NB_DATA (NB_DATA),
    .NB_OP   (NB_OP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .rx_empty     (rx_empty),
    .r_data       (r_data),
    .rd_uart      (rd_uart),
    .tx_full      (tx_full),
    .w_data       (w_data),
    .wr_uart      (wr_uart),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .i_alu_result (i_alu_result),
    .o_busy       (o_busy),
    .o_timeout    (o_timeout)
  );

  // Reference combinational ALU feeding the sequencer.
  always_comb begin
    i_alu_result = '0;
    case (o_alu_op)
      OP_ADD: i_alu_result = o_alu_a + o_alu_b;
      OP_SUB: i_alu_result = o_alu_a - o_alu_b;
      OP_AND: i_alu_result = o_alu_a & o_alu_b;
      OP_OR:  i_alu_result = o_alu_a | o_alu_b;
      OP_XOR: i_alu_result = o_alu_a ^ o_alu_b;
      OP_NOR: i_alu_result = ~(o_alu_a | o_alu_b);
      OP_SRL: i_alu_result = o_alu_a >> o_alu_b;
      OP_SRA: i_alu_result = $signed(o_alu_a) >>> o_alu_b;
      default: i_alu_result = '0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic rx_sync();
    rx_empty = (rxq.size() == 0);
    r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    rxq.push_back(b);
    rx_sync();
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [7:0] exp);
    push_byte(a);
    push_byte(b);
    push_byte(op);
    expq.push_back(exp);
  endtask

  task automatic wait_wr(input int target, input string tag);
    int n = 0;
    while (wr_count < target && n < 300) begin
      tick(1);
      n++;
    end
    check_eq(tag, wr_count, target);
  endtask

  task automatic wait_rd(input int target, input string tag);
    int n = 0;
    while (rd_count < target && n < 300) begin
      tick(1);
      n++;
    end
    check_eq(tag, rd_count, target);
  endtask

  task automatic wait_to(input int target, input string tag);
    int n = 0;
    while (to_count < target && n < 300) begin
      tick(1);
      n++;
    end
    check_eq(tag, to_count, target);
  endtask

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Monitor on the falling edge: models the RX FIFO pop and scores TX pushes.
  initial forever begin
    @(negedge i_clk);
    if (rd_uart) begin
      check_eq("rd_back_to_back", prev_rd, 0);
      check_eq("rd_nonempty", (rxq.size() != 0), 1);
      if (rxq.size() != 0) void'(rxq.pop_front());
      rx_sync();
      rd_count++;
      last_rd_cyc = cyc;
    end
    if (wr_uart) begin
      check_eq("wr_while_full", prev_full, 0);
      if (expq.size() == 0) check_eq("wr_unexpected", expq.size(), 1);
      else check_eq("w_data", w_data, expq.pop_front());
      wr_count++;
      last_wr_cyc = cyc;
    end
    if (o_timeout) begin
      to_count++;
      last_to_cyc = cyc;
    end
    prev_rd   = rd_uart;
    prev_full = tx_full;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset values
    tick(3);
    check_eq("rst_rd_uart", rd_uart, 0);
    check_eq("rst_wr_uart", wr_uart, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_timeout", o_timeout, 0);
    check_eq("rst_alu", {o_alu_a, o_alu_b, o_alu_op}, 0);
    check_eq("rst_w_data", w_data, 0);
    i_reset = 1'b1;
    tick(2);

    // ADD frame, free TX
    send_frame(8'h05, 8'h03, {2'b00, OP_ADD}, 8'h08);
    wait_wr(1, "t1_wr_seen");
    check_eq("t1_latency", last_wr_cyc - last_rd_cyc, 2);
    check_eq("t1_alu_a", o_alu_a, 8'h05);
    check_eq("t1_alu_b", o_alu_b, 8'h03);
    check_eq("t1_alu_op", o_alu_op, 6'h20);
    check_eq("t1_idle", o_busy, 0);

    // Same frame with TX full for a while
    tx_full = 1'b1;
    send_frame(8'h05, 8'h03, {2'b00, OP_ADD}, 8'h08);
    tick(20);
    check_eq("t2_held", wr_count, 1);
    check_eq("t2_busy", o_busy, 1);
    tx_full = 1'b0;
    wait_wr(2, "t2_wr_seen");
    tick(3);
    check_eq("t2_single_push", wr_count, 2);

    // Partial frame times out
    base = wr_count;
    push_byte(8'h07);
    wait_to(1, "t3_timeout_seen");
    check_eq("t3_to_delay", last_to_cyc - last_rd_cyc, TIMEOUT);
    check_eq("t3_to_pulse", o_timeout, 0);
    check_eq("t3_idle", o_busy, 0);
    tick(5);
    check_eq("t3_no_push", wr_count, base);
    check_eq("t3_a_kept", o_alu_a, 8'h07);

    // Upper opcode bits ignored: 0xE2 decodes as SUB
    send_frame(8'h09, 8'h04, 8'hE2, 8'h05);
    wait_wr(base + 1, "t4_wr_seen");
    check_eq("t4_alu_op", o_alu_op, 6'b100010);

    // Two frames preloaded back to back
    base = wr_count;
    send_frame(8'hA5, 8'h0F, {2'b00, OP_XOR}, 8'hAA);
    send_frame(8'h81, 8'h02, {2'b00, OP_SRA}, 8'hE0);
    wait_wr(base + 2, "t5_two_results");
    check_eq("t5_alu_op", o_alu_op, OP_SRA);

    // Reset while waiting for the opcode byte
    base = rd_count;
    push_byte(8'h01);
    push_byte(8'h02);
    wait_rd(base + 2, "t6_two_pops");
    check_eq("t6_busy_before", o_busy, 1);
    i_reset = 1'b0;
    #1;
    check_eq("t6_busy", o_busy, 0);
    check_eq("t6_alu", {o_alu_a, o_alu_b, o_alu_op}, 0);
    check_eq("t6_w_data", w_data, 0);
    check_eq("t6_strobes", {rd_uart, wr_uart, o_timeout}, 0);
    tick(2);
    i_reset = 1'b1;
    tick(1);
    base = wr_count;
    send_frame(8'h30, 8'h0C, {2'b00, OP_OR}, 8'h3C);
    wait_wr(base + 1, "t6_fresh_frame");
    check_eq("t6_alu_a", o_alu_a, 8'h30);

    tick(3);
    check_eq("scoreboard_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
